// File: rtl/cpu_regfile_ctx.sv
// 6502-style register file (A, X, Y, SP, PC, PS) with a hardware context
// save/restore sequencer. The sequencer pushes PCH, PCL, PS onto the stack
// page or pulls PS, PCL, PCH back over a req/ack memory port. It serves
// as the interrupt-entry and RTI engine.
module cpu_regfile_ctx #(
    parameter int                   DATA_W     = 8,
    parameter int                   ADDR_W     = 16,
    parameter logic [ADDR_W-1:0]    PC_RESET   = 16'h1000,
    parameter logic [DATA_W-1:0]    SP_RESET   = 8'hFD,
    parameter logic [DATA_W-1:0]    PS_RESET   = 8'h34,
    parameter logic [DATA_W-1:0]    STACK_PAGE = 8'h01,
    parameter int                   IMASK_BIT  = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                we_a,
    input  logic                we_x,
    input  logic                we_y,
    input  logic                we_sp,
    input  logic                we_pc,
    input  logic                pc_inc,
    input  logic [1:0]          sp_op,
    input  logic [DATA_W-1:0]   data_in,
    input  logic [ADDR_W-1:0]   pc_in,
    input  logic [DATA_W-1:0]   flags_in,
    input  logic [DATA_W-1:0]   flags_mask,
    input  logic                ctx_save,
    input  logic                ctx_restore,
    output logic                ctx_busy,
    output logic                ctx_done,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ack,
    output logic [DATA_W-1:0]   A,
    output logic [DATA_W-1:0]   X,
    output logic [DATA_W-1:0]   Y,
    output logic [DATA_W-1:0]   SP,
    output logic [DATA_W-1:0]   PS,
    output logic [ADDR_W-1:0]   PC
);

    localparam logic [DATA_W-1:0] ONE_D = 1;
    localparam logic [ADDR_W-1:0] ONE_A = 1;

    typedef enum logic [2:0] {
        IDLE, S_PCH, S_PCL, S_PS, R_PS, R_PCL, R_PCH, DONE
    } state_t;

    state_t             state_reg;
    logic [DATA_W-1:0]  a_reg, x_reg, y_reg, sp_reg, ps_reg, pcl_hold_reg;
    logic [ADDR_W-1:0]  pc_reg;
    logic               busy_reg, done_reg, req_reg, mem_we_reg;
    logic [ADDR_W-1:0]  mem_addr_reg;
    logic [DATA_W-1:0]  mem_wdata_reg;

    // Values SP/PC/PS take at the next edge when the sequencer is idle.
    logic [DATA_W-1:0]  sp_idle_next, sp_idle_inc, ps_idle_next;
    logic [ADDR_W-1:0]  pc_idle_next;
    logic [DATA_W-1:0]  sp_inc, sp_inc2, sp_dec;

    // Idle-state SP and PC update: explicit load beats arithmetic.
    always_comb begin
        sp_idle_next = sp_reg;
        if (we_sp)
            sp_idle_next = data_in;
        else if (sp_op == 2'b01)
            sp_idle_next = sp_reg + ONE_D;
        else if (sp_op == 2'b10)
            sp_idle_next = sp_reg - ONE_D;

        pc_idle_next = pc_reg;
        if (we_pc)
            pc_idle_next = pc_in;
        else if (pc_inc)
            pc_idle_next = pc_reg + ONE_A;
    end

    // Per-bit masked flag merge.
    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_flag
            assign ps_idle_next[gi] = flags_mask[gi] ? flags_in[gi] : ps_reg[gi];
        end
    endgenerate

    assign sp_idle_inc = sp_idle_next + ONE_D;
    assign sp_inc      = sp_reg + ONE_D;
    assign sp_inc2     = sp_inc + ONE_D;
    assign sp_dec      = sp_reg - ONE_D;

    // A/X/Y loads are honoured regardless of sequencer activity.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_reg <= '0;
            x_reg <= '0;
            y_reg <= '0;
        end else begin
            if (we_a) a_reg <= data_in;
            if (we_x) x_reg <= data_in;
            if (we_y) y_reg <= data_in;
        end
    end

    // Sequencer with SP/PC/PS ownership and registered memory-port outputs.
    // Stack addresses are computed one cycle ahead so that mem_addr stays
    // stable for the whole handshake and only moves after an ack.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            sp_reg        <= SP_RESET;
            ps_reg        <= PS_RESET;
            pc_reg        <= PC_RESET;
            pcl_hold_reg  <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            req_reg       <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    sp_reg <= sp_idle_next;
                    pc_reg <= pc_idle_next;
                    ps_reg <= ps_idle_next;
                    if (ctx_save) begin
                        state_reg     <= S_PCH;
                        busy_reg      <= 1'b1;
                        req_reg       <= 1'b1;
                        mem_we_reg    <= 1'b1;
                        mem_addr_reg  <= {STACK_PAGE, sp_idle_next};
                        mem_wdata_reg <= pc_idle_next[ADDR_W-1:DATA_W];
                    end else if (ctx_restore) begin
                        state_reg    <= R_PS;
                        busy_reg     <= 1'b1;
                        req_reg      <= 1'b1;
                        mem_we_reg   <= 1'b0;
                        mem_addr_reg <= {STACK_PAGE, sp_idle_inc};
                    end
                end
                S_PCH: if (mem_ack) begin
                    sp_reg        <= sp_dec;
                    state_reg     <= S_PCL;
                    mem_addr_reg  <= {STACK_PAGE, sp_dec};
                    mem_wdata_reg <= pc_reg[DATA_W-1:0];
                end
                S_PCL: if (mem_ack) begin
                    sp_reg        <= sp_dec;
                    state_reg     <= S_PS;
                    mem_addr_reg  <= {STACK_PAGE, sp_dec};
                    mem_wdata_reg <= ps_reg;
                end
                S_PS: if (mem_ack) begin
                    // The pushed copy is the value before the interrupt mask is set.
                    sp_reg              <= sp_dec;
                    ps_reg[IMASK_BIT]   <= 1'b1;
                    state_reg           <= DONE;
                    busy_reg            <= 1'b0;
                    req_reg             <= 1'b0;
                    mem_we_reg          <= 1'b0;
                    done_reg            <= 1'b1;
                end
                R_PS: if (mem_ack) begin
                    sp_reg       <= sp_inc;
                    ps_reg       <= mem_rdata;
                    state_reg    <= R_PCL;
                    mem_addr_reg <= {STACK_PAGE, sp_inc2};
                end
                R_PCL: if (mem_ack) begin
                    sp_reg       <= sp_inc;
                    pcl_hold_reg <= mem_rdata;
                    state_reg    <= R_PCH;
                    mem_addr_reg <= {STACK_PAGE, sp_inc2};
                end
                R_PCH: if (mem_ack) begin
                    // Both PC bytes land together so PC is never half-restored.
                    sp_reg    <= sp_inc;
                    pc_reg    <= {mem_rdata, pcl_hold_reg};
                    state_reg <= DONE;
                    busy_reg  <= 1'b0;
                    req_reg   <= 1'b0;
                    done_reg  <= 1'b1;
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign A         = a_reg;
    assign X         = x_reg;
    assign Y         = y_reg;
    assign SP        = sp_reg;
    assign PS        = ps_reg;
    assign PC        = pc_reg;
    assign ctx_busy  = busy_reg;
    assign ctx_done  = done_reg;
    assign mem_req   = req_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;

endmodule
